// File: rtl/sort_accel_param.sv
// In-place bubble-sort engine: CPU slave for CSRs, SDRAM master with one read per compare step.
// Master strobes are held until waitrequest drops; CSR writes to 0-2 stall while a sort runs.
module sort_accel_param #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int STRIDE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [2:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata,
    output logic        irq
);

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        CMP,
        WR_A,
        WR_B,
        NEXT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               desc_q, desc_d;
    logic               sgn_q, sgn_d;
    logic               irq_en_q, irq_en_d;
    logic [31:0]        swaps_q, swaps_d;
    logic [31:0]        passes_q, passes_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   limit_q, limit_d;
    logic               swapped_q, swapped_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;

    logic               busy;
    logic               wr_acc;
    logic               start;
    logic [LEN_W-1:0]   idx_inc;
    logic [31:0]        addr_a;
    logic [31:0]        addr_b;
    logic [DATA_W-1:0]  a_key;
    logic [DATA_W-1:0]  b_key;
    logic               a_gt_b;
    logic               a_lt_b;
    logic               do_swap;

    assign busy    = (state_q != IDLE);
    assign slave_waitrequest = slave_write && (slave_address <= 3'd2) && busy;
    assign wr_acc  = slave_write && !slave_waitrequest;
    assign start   = wr_acc && (slave_address == 3'd0) && slave_writedata[0];
    assign idx_inc = idx_q + LEN_W'(1);
    assign addr_a  = base_q + 32'(idx_q) * 32'(STRIDE);
    assign addr_b  = base_q + 32'(idx_inc) * 32'(STRIDE);
    assign irq     = done_q & irq_en_q;

    // Only the low DATA_W bits take part in the compare; upper bits ride along untouched.
    assign a_key = a_q[DATA_W-1:0];
    assign b_key = b_q[DATA_W-1:0];

    always_comb begin
        a_gt_b = 1'b0;
        a_lt_b = 1'b0;
        if (sgn_q) begin
            a_gt_b = $signed(a_key) > $signed(b_key);
            a_lt_b = $signed(a_key) < $signed(b_key);
        end else begin
            a_gt_b = a_key > b_key;
            a_lt_b = a_key < b_key;
        end
    end

    assign do_swap = desc_q ? a_lt_b : a_gt_b;

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                3'd1:    slave_readdata = base_q;
                3'd2:    slave_readdata = 32'(len_q);
                3'd3:    slave_readdata = {30'd0, done_q, busy};
                3'd4:    slave_readdata = swaps_q;
                3'd5:    slave_readdata = passes_q;
                default: slave_readdata = '0;
            endcase
        end
    end

    always_comb begin
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state_q)
            RD_A: begin
                master_read    = 1'b1;
                master_address = addr_a;
            end
            RD_B: begin
                master_read    = 1'b1;
                master_address = addr_b;
            end
            WR_A: begin
                master_write     = 1'b1;
                master_address   = addr_a;
                master_writedata = b_q;
            end
            WR_B: begin
                master_write     = 1'b1;
                master_address   = addr_b;
                master_writedata = a_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        desc_d    = desc_q;
        sgn_d     = sgn_q;
        irq_en_d  = irq_en_q;
        swaps_d   = swaps_q;
        passes_d  = passes_q;
        done_d    = done_q;
        idx_d     = idx_q;
        limit_d   = limit_q;
        swapped_d = swapped_q;
        a_d       = a_q;
        b_d       = b_q;

        if (wr_acc) begin
            case (slave_address)
                3'd0: begin
                    desc_d   = slave_writedata[1];
                    sgn_d    = slave_writedata[2];
                    irq_en_d = slave_writedata[3];
                end
                3'd1:    base_d = slave_writedata;
                3'd2:    len_d  = slave_writedata[LEN_W-1:0];
                3'd3:    done_d = 1'b0;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    swaps_d   = '0;
                    passes_d  = '0;
                    done_d    = 1'b0;
                    limit_d   = len_q - LEN_W'(1);
                    idx_d     = '0;
                    swapped_d = 1'b0;
                    state_d   = (len_q < LEN_W'(2)) ? DONE : RD_A;
                end
            end
            RD_A: if (!master_waitrequest) state_d = WAIT_A;
            WAIT_A: begin
                if (master_readdatavalid) begin
                    a_d     = master_readdata;
                    state_d = RD_B;
                end
            end
            RD_B: if (!master_waitrequest) state_d = WAIT_B;
            WAIT_B: begin
                if (master_readdatavalid) begin
                    b_d     = master_readdata;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (do_swap) begin
                    swaps_d   = swaps_q + 32'd1;
                    swapped_d = 1'b1;
                    state_d   = WR_A;
                end else begin
                    // b stays at i+1, so it becomes the next step's left operand.
                    a_d     = b_q;
                    state_d = NEXT;
                end
            end
            WR_A: if (!master_waitrequest) state_d = WR_B;
            WR_B: if (!master_waitrequest) state_d = NEXT;
            NEXT: begin
                if (idx_inc == limit_q) begin
                    passes_d = passes_q + 32'd1;
                    if (!swapped_q || (limit_q == LEN_W'(1))) begin
                        state_d = DONE;
                    end else begin
                        limit_d   = limit_q - LEN_W'(1);
                        idx_d     = '0;
                        swapped_d = 1'b0;
                        state_d   = RD_A;
                    end
                end else begin
                    idx_d   = idx_inc;
                    state_d = RD_B;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            desc_q    <= 1'b0;
            sgn_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            swaps_q   <= '0;
            passes_q  <= '0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            limit_q   <= '0;
            swapped_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            desc_q    <= desc_d;
            sgn_q     <= sgn_d;
            irq_en_q  <= irq_en_d;
            swaps_q   <= swaps_d;
            passes_q  <= passes_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            limit_q   <= limit_d;
            swapped_q <= swapped_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

endmodule

// File: tb/tb_sort_accel_param.sv
// Directed bench for sort_accel_param (DATA_W=8) with a behavioural SDRAM responder.
module tb_sort_accel_param;
    localparam int          DW   = 8;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MEMN = 32;

    logic        clk, rst_n;
    logic        slave_waitrequest, slave_read, slave_write;
    logic [2:0]  slave_address;
    logic [31:0] slave_readdata, slave_writedata;
    logic        master_waitrequest, master_read, master_readdatavalid, master_write;
    logic [31:0] master_address, master_readdata, master_writedata;
    logic        irq;

    sort_accel_param #(.DATA_W(DW), .LEN_W(16), .STRIDE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_readdata(slave_readdata),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .master_waitrequest(master_waitrequest), .master_address(master_address),
        .master_read(master_read), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_write(master_write),
        .master_writedata(master_writedata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [MEMN];
    logic [31:0] exp16 [16];
    bit          rnd_stall = 0;
    bit          hold_wr   = 0;
    int          rd_dly_max = 1;
    int          stall_left = 0, rd_cnt = 0, wr_cnt = 0, strobe_cyc = 0;
    int          bad_addr = 0, unstable = 0;
    logic [31:0] rd_log [4];
    logic [31:0] wr_addr_log [4];
    logic [31:0] wr_dat_log [4];
    bit          rd_pend = 0;
    int          rd_dly = 0, m_idx = 0;
    logic [31:0] rd_word, m_off;
    bit          prev_stalled = 0;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_wdat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // SDRAM responder: decides waitrequest at each negedge for the following posedge.
    initial begin
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            master_readdatavalid = 1'b0;
            if (!rst_n) begin
                rd_pend = 0; stall_left = 0; prev_stalled = 0;
                master_waitrequest = 1'b0;
            end else begin
                if (rd_pend) begin
                    if (rd_dly == 0) begin
                        master_readdatavalid = 1'b1;
                        master_readdata = rd_word;
                        rd_pend = 0;
                    end else rd_dly--;
                end
                if (prev_stalled && (master_read !== prev_rd || master_write !== prev_wr ||
                    master_address !== prev_addr || (prev_wr && master_writedata !== prev_wdat)))
                    unstable++;
                prev_stalled = 0;
                master_waitrequest = 1'b0;
                if (master_read || master_write) begin
                    strobe_cyc++;
                    if (stall_left > 0) begin
                        master_waitrequest = 1'b1;
                        stall_left--;
                        prev_stalled = 1;
                        prev_rd = master_read; prev_wr = master_write;
                        prev_addr = master_address; prev_wdat = master_writedata;
                    end else begin
                        m_off = master_address - BASE;
                        m_idx = int'(m_off >> 2);
                        if (master_address < BASE || m_off[1:0] != 2'd0 || m_off >= MEMN * 4) begin
                            bad_addr++;
                        end else if (master_read) begin
                            if (rd_cnt < 4) rd_log[rd_cnt] = master_address;
                            rd_cnt++;
                            rd_pend = 1;
                            rd_word = mem[m_idx];
                            rd_dly  = $urandom_range(rd_dly_max - 1, 0);
                        end else begin
                            mem[m_idx] = master_writedata;
                            if (wr_cnt < 4) begin
                                wr_addr_log[wr_cnt] = master_address;
                                wr_dat_log[wr_cnt]  = master_writedata;
                            end
                            wr_cnt++;
                        end
                        if (hold_wr && master_write) stall_left = 1000000;
                        else stall_left = rnd_stall ? $urandom_range(3, 0) : 0;
                    end
                end
            end
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d, output int stalls);
        stalls = 0;
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        #1;
        while (slave_waitrequest && stalls < 20000) begin
            @(negedge clk); #1; stalls++;
        end
        if (stalls >= 20000) check("slave_write_timeout", 32'd1, 32'd0);
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        #1;
        d = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        int n;
        st = '0; n = 0;
        while (st[1] !== 1'b1 && n < 20000) begin
            cpu_read(3'd3, st); n++;
        end
        check({tag, ".done"}, {31'd0, st[1]}, 32'd1);
    endtask

    task automatic start_sort(input int len, input logic [3:0] mode);
        int s;
        rd_cnt = 0; wr_cnt = 0; strobe_cyc = 0;
        cpu_write(3'd1, BASE, s);
        cpu_write(3'd2, len, s);
        cpu_write(3'd0, {28'd0, mode} | 32'd1, s);
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cpu_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] key;
        int j, s, n;
        rst_n = 1'b0;
        slave_read = 1'b0; slave_write = 1'b0;
        slave_address = '0; slave_writedata = '0;
        #12;
        check("rst.mread",  {31'd0, master_read}, 32'd0);
        check("rst.mwrite", {31'd0, master_write}, 32'd0);
        check("rst.maddr",  master_address, 32'd0);
        check("rst.irq",    {31'd0, irq}, 32'd0);
        check("rst.swait",  {31'd0, slave_waitrequest}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        read_chk("rst.status", 3'd3, 32'd0);
        read_chk("rst.swaps",  3'd4, 32'd0);
        read_chk("rst.passes", 3'd5, 32'd0);
        read_chk("rst.base",   3'd1, 32'd0);
        read_chk("rst.len",    3'd2, 32'd0);
        cpu_write(3'd1, 32'hDEAD_BEEF, s);
        read_chk("base.rw", 3'd1, 32'hDEAD_BEEF);
        cpu_write(3'd2, 32'h0003_0007, s);
        read_chk("len.rw", 3'd2, 32'h0000_0007);
        read_chk("unmapped", 3'd7, 32'd0);

        // Two elements, one swap.
        mem[0] = 32'd1; mem[1] = 32'd0;
        start_sort(2, 4'b0000);
        wait_done("t2");
        check("t2.rdcnt", rd_cnt, 32'd2);
        check("t2.rd0", rd_log[0], BASE);
        check("t2.rd1", rd_log[1], BASE + 32'd4);
        check("t2.wrcnt", wr_cnt, 32'd2);
        check("t2.wa0", wr_addr_log[0], BASE);
        check("t2.wd0", wr_dat_log[0], 32'd0);
        check("t2.wa1", wr_addr_log[1], BASE + 32'd4);
        check("t2.wd1", wr_dat_log[1], 32'd1);
        read_chk("t2.swaps", 3'd4, 32'd1);
        read_chk("t2.passes", 3'd5, 32'd1);
        read_chk("t2.status", 3'd3, 32'd2);

        // Reversed five elements.
        for (int i = 0; i < 5; i++) mem[i] = 32'(5 - i);
        start_sort(5, 4'b0000);
        wait_done("t5");
        for (int i = 0; i < 5; i++) check($sformatf("t5.mem%0d", i), mem[i], 32'(i + 1));
        check("t5.rdcnt", rd_cnt, 32'd14);
        check("t5.wrcnt", wr_cnt, 32'd20);
        read_chk("t5.swaps", 3'd4, 32'd10);
        read_chk("t5.passes", 3'd5, 32'd4);
        check("t5.irq", {31'd0, irq}, 32'd0);

        // Already sorted: early exit, irq enabled.
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        start_sort(4, 4'b1000);
        wait_done("t4");
        check("t4.irq", {31'd0, irq}, 32'd1);
        check("t4.rdcnt", rd_cnt, 32'd4);
        check("t4.wrcnt", wr_cnt, 32'd0);
        read_chk("t4.swaps", 3'd4, 32'd0);
        read_chk("t4.passes", 3'd5, 32'd1);
        cpu_write(3'd3, 32'd0, s);
        #1 check("t4.irq_clr", {31'd0, irq}, 32'd0);
        read_chk("t4.status_clr", 3'd3, 32'd0);

        // 8-bit keys: signed descending, then unsigned ascending.
        mem[0] = 32'h7F; mem[1] = 32'h80; mem[2] = 32'h01;
        start_sort(3, 4'b0110);
        wait_done("sd");
        check("sd.mem0", mem[0], 32'h7F);
        check("sd.mem1", mem[1], 32'h01);
        check("sd.mem2", mem[2], 32'h80);
        read_chk("sd.swaps", 3'd4, 32'd1);
        read_chk("sd.passes", 3'd5, 32'd2);
        mem[0] = 32'h7F; mem[1] = 32'h80; mem[2] = 32'h01;
        start_sort(3, 4'b0000);
        wait_done("ua");
        check("ua.mem0", mem[0], 32'h01);
        check("ua.mem1", mem[1], 32'h7F);
        check("ua.mem2", mem[2], 32'h80);
        read_chk("ua.swaps", 3'd4, 32'd2);

        // LEN 0 and 1: done two cycles after start, no master traffic.
        for (int l = 0; l < 2; l++) begin
            start_sort(l, 4'b0000);
            read_chk($sformatf("len%0d.status", l), 3'd3, 32'd2);
            check($sformatf("len%0d.strobes", l), strobe_cyc, 32'd0);
        end

        // Random stalls and read latency, plus a CTRL write issued mid-sort.
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            exp16[i] = mem[i];
        end
        for (int i = 1; i < 16; i++) begin
            key = exp16[i];
            j = i - 1;
            while (j >= 0 && exp16[j][7:0] > key[7:0]) begin
                exp16[j + 1] = exp16[j];
                j--;
            end
            exp16[j + 1] = key;
        end
        rnd_stall = 1; rd_dly_max = 4;
        start_sort(16, 4'b0000);
        repeat (3) @(negedge clk);
        cpu_write(3'd0, 32'd0, s);
        check("rnd.busy_stall", {31'd0, (s > 0)}, 32'd1);
        read_chk("rnd.status", 3'd3, 32'd2);
        for (int i = 0; i < 16; i++) check($sformatf("rnd.mem%0d", i), mem[i], exp16[i]);
        rnd_stall = 0; rd_dly_max = 1;

        // Async reset while the second write of a swap is stalled.
        mem[0] = 32'd3; mem[1] = 32'd2; mem[2] = 32'd1;
        hold_wr = 1;
        start_sort(3, 4'b1000);
        n = 0;
        while (wr_cnt < 1 && n < 1000) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk); #1;
        check("rstwr.mwrite", {31'd0, master_write}, 32'd1);
        check("rstwr.addr", master_address, BASE + 32'd4);
        check("rstwr.wdata", master_writedata, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rstwr.mwrite0", {31'd0, master_write}, 32'd0);
        check("rstwr.mread0",  {31'd0, master_read}, 32'd0);
        check("rstwr.addr0",   master_address, 32'd0);
        check("rstwr.wdata0",  master_writedata, 32'd0);
        check("rstwr.irq0",    {31'd0, irq}, 32'd0);
        check("rstwr.swait0",  {31'd0, slave_waitrequest}, 32'd0);
        hold_wr = 0;
        @(negedge clk); #2 rst_n = 1'b1;
        read_chk("rstwr.status", 3'd3, 32'd0);
        read_chk("rstwr.swaps", 3'd4, 32'd0);
        check("rstwr.mem0", mem[0], 32'd2);
        check("rstwr.mem1", mem[1], 32'd2);
        repeat (5) @(negedge clk);
        check("rstwr.idle", {31'd0, master_read | master_write}, 32'd0);

        check("strobe_stable", unstable, 32'd0);
        check("addr_range", bad_addr, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
